// File: rtl/snes_cart_map.sv
// SNES cartridge address mapper and memory-request sequencer.
// Decodes LoROM/HiROM/ExHiROM CPU accesses into ROM and save-RAM requests,
// returns read data to the CPU and otherwise drives the open-bus value.
`timescale 1ns / 1ps
module snes_cart_map #(
   parameter int unsigned ROM_AW = 24,
   parameter int unsigned RAM_AW = 17
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [23:0]       ca,
   input  logic [7:0]        di,
   input  logic              cpurd_n,
   input  logic              cpuwr_n,
   input  logic              romsel_n,
   input  logic              sysclkf_ce,
   input  logic              sysclkr_ce,
   input  logic [1:0]        map_mode,
   input  logic [ROM_AW-1:0] rom_mask,
   input  logic [RAM_AW-1:0] ram_mask,
   output logic [ROM_AW-1:0] rom_addr,
   output logic              rom_req,
   input  logic              rom_ack,
   input  logic [15:0]       rom_q,
   output logic [RAM_AW-1:0] ram_addr,
   output logic              ram_req,
   output logic              ram_we,
   output logic [7:0]        ram_d,
   input  logic              ram_ack,
   input  logic [7:0]        ram_q,
   output logic [7:0]        cart_do,
   output logic [7:0]        late_cnt
);

   typedef enum logic [2:0] {
      StIdle,
      StRomWait,
      StRamRdWait,
      StRamWrArm,
      StRamWrWait
   } state_e;

   state_e              state_q, state_d;
   logic [ROM_AW-1:0]   rom_addr_q, rom_addr_d;
   logic [RAM_AW-1:0]   ram_addr_q, ram_addr_d;
   logic                rom_req_q, rom_req_d;
   logic                ram_req_q, ram_req_d;
   logic                ram_we_q, ram_we_d;
   logic [7:0]          ram_d_q, ram_d_d;
   logic [7:0]          data_q, data_d;
   logic [7:0]          openbus_q, openbus_d;
   logic                hit_q, hit_d;
   logic [7:0]          late_cnt_q, late_cnt_d;

   logic [23:0]         rom_raw;
   logic [18:0]         ram_raw;
   logic                rom_hit, ram_hit;
   logic [ROM_AW-1:0]   rom_dec;
   logic [RAM_AW-1:0]   ram_dec;
   logic                late_inc;

   // Address decode for the selected mapping mode, masked and resized.
   always_comb begin
      rom_raw = '0;
      ram_raw = '0;
      rom_hit = 1'b0;
      ram_hit = 1'b0;
      rom_dec = '0;
      ram_dec = '0;
      case (map_mode)
         2'd1, 2'd2: begin
            rom_hit = !romsel_n;
            ram_hit = (ca[22:21] == 2'b01) && (ca[15:13] == 3'b011) &&
                      ((map_mode == 2'd1) || ca[23]);
            rom_raw = (map_mode == 2'd2) ? {1'b0, ~ca[23], ca[21:0]} : {2'b00, ca[21:0]};
            ram_raw = {1'b0, ca[20:16], ca[12:0]};
         end
         default: begin
            rom_hit = !romsel_n && (ca[15] || ca[22]);
            ram_hit = !romsel_n && (ca[22:20] == 3'b111) && !ca[15];
            rom_raw = {2'b00, ca[22:16], ca[14:0]};
            ram_raw = {ca[19:16], ca[14:0]};
         end
      endcase
      // An all-zero RAM mask means the cartridge has no save RAM.
      ram_hit = ram_hit && (|ram_mask);
      // Zero-extend or truncate the raw addresses to the port widths.
      for (int unsigned i = 0; i < ROM_AW; i++) begin
         rom_dec[i] = (i < 24) ? rom_raw[i % 24] : 1'b0;
      end
      for (int unsigned i = 0; i < RAM_AW; i++) begin
         ram_dec[i] = (i < 19) ? ram_raw[i % 19] : 1'b0;
      end
      rom_dec = rom_dec & rom_mask;
      ram_dec = ram_dec & ram_mask;
   end

   // Sequencer next-state, request handshakes, data capture and late counter.
   always_comb begin
      state_d    = state_q;
      rom_addr_d = rom_addr_q;
      ram_addr_d = ram_addr_q;
      rom_req_d  = rom_req_q;
      ram_req_d  = ram_req_q;
      ram_we_d   = ram_we_q;
      ram_d_d    = ram_d_q;
      data_d     = data_q;
      hit_d      = hit_q;
      late_cnt_d = late_cnt_q;
      openbus_d  = sysclkr_ce ? di : openbus_q;

      unique case (state_q)
         StIdle: begin
            if (sysclkf_ce) begin
               hit_d = 1'b0;
               if (ram_hit && !cpurd_n) begin
                  ram_addr_d = ram_dec;
                  ram_req_d  = 1'b1;
                  ram_we_d   = 1'b0;
                  hit_d      = 1'b1;
                  state_d    = StRamRdWait;
               end else if (ram_hit && !cpuwr_n) begin
                  ram_addr_d = ram_dec;
                  state_d    = StRamWrArm;
               end else if (rom_hit && !cpurd_n) begin
                  rom_addr_d = rom_dec;
                  rom_req_d  = 1'b1;
                  hit_d      = 1'b1;
                  state_d    = StRomWait;
               end
            end
         end
         StRomWait: begin
            if (rom_ack) begin
               rom_req_d = 1'b0;
               data_d    = rom_addr_q[0] ? rom_q[15:8] : rom_q[7:0];
               state_d   = StIdle;
            end
         end
         StRamRdWait: begin
            if (ram_ack) begin
               ram_req_d = 1'b0;
               data_d    = ram_q;
               state_d   = StIdle;
            end
         end
         StRamWrArm: begin
            // Write data is only stable on the rising CPU phase.
            if (sysclkr_ce) begin
               ram_d_d   = di;
               ram_req_d = 1'b1;
               ram_we_d  = 1'b1;
               state_d   = StRamWrWait;
            end
         end
         StRamWrWait: begin
            if (ram_ack) begin
               ram_req_d = 1'b0;
               ram_we_d  = 1'b0;
               state_d   = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      // Read not served in time, or a new access arriving while busy (dropped).
      late_inc = (sysclkr_ce && ((state_q == StRomWait) || (state_q == StRamRdWait))) ||
                 (sysclkf_ce && (rom_hit || ram_hit) && (state_q != StIdle));
      if (late_inc && (late_cnt_q != 8'hFF)) begin
         late_cnt_d = late_cnt_q + 8'd1;
      end
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         rom_addr_q <= '0;
         ram_addr_q <= '0;
         rom_req_q  <= 1'b0;
         ram_req_q  <= 1'b0;
         ram_we_q   <= 1'b0;
         ram_d_q    <= 8'h00;
         data_q     <= 8'hFF;
         openbus_q  <= 8'hFF;
         hit_q      <= 1'b0;
         late_cnt_q <= 8'h00;
      end else begin
         state_q    <= state_d;
         rom_addr_q <= rom_addr_d;
         ram_addr_q <= ram_addr_d;
         rom_req_q  <= rom_req_d;
         ram_req_q  <= ram_req_d;
         ram_we_q   <= ram_we_d;
         ram_d_q    <= ram_d_d;
         data_q     <= data_d;
         openbus_q  <= openbus_d;
         hit_q      <= hit_d;
         late_cnt_q <= late_cnt_d;
      end
   end

   // Outputs: read data once the access has completed, otherwise open bus.
   always_comb begin
      rom_addr = rom_addr_q;
      ram_addr = ram_addr_q;
      rom_req  = rom_req_q;
      ram_req  = ram_req_q;
      ram_we   = ram_we_q;
      ram_d    = ram_d_q;
      late_cnt = late_cnt_q;
      cart_do  = (hit_q && (state_q == StIdle)) ? data_q : openbus_q;
   end

endmodule

// File: tb/tb_snes_cart_map.sv
// Directed bench for snes_cart_map with a read-data scoreboard.
`timescale 1ns / 1ps
module tb_snes_cart_map;

   localparam int unsigned ROM_AW = 24;
   localparam int unsigned RAM_AW = 17;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [23:0]       ca = '0;
   logic [7:0]        di = '0;
   logic              cpurd_n = 1'b1;
   logic              cpuwr_n = 1'b1;
   logic              romsel_n = 1'b1;
   logic              sysclkf_ce = 1'b0;
   logic              sysclkr_ce = 1'b0;
   logic [1:0]        map_mode = 2'd0;
   logic [ROM_AW-1:0] rom_mask = 24'hFFFFFF;
   logic [RAM_AW-1:0] ram_mask = 17'h1FFFF;
   logic [ROM_AW-1:0] rom_addr;
   logic              rom_req;
   logic              rom_ack = 1'b0;
   logic [15:0]       rom_q = '0;
   logic [RAM_AW-1:0] ram_addr;
   logic              ram_req;
   logic              ram_we;
   logic [7:0]        ram_d;
   logic              ram_ack = 1'b0;
   logic [7:0]        ram_q = '0;
   logic [7:0]        cart_do;
   logic [7:0]        late_cnt;

   int checks = 0;
   int errors = 0;
   logic [7:0] sb[$];

   snes_cart_map #(.ROM_AW(ROM_AW), .RAM_AW(RAM_AW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ca         (ca),
      .di         (di),
      .cpurd_n    (cpurd_n),
      .cpuwr_n    (cpuwr_n),
      .romsel_n   (romsel_n),
      .sysclkf_ce (sysclkf_ce),
      .sysclkr_ce (sysclkr_ce),
      .map_mode   (map_mode),
      .rom_mask   (rom_mask),
      .ram_mask   (ram_mask),
      .rom_addr   (rom_addr),
      .rom_req    (rom_req),
      .rom_ack    (rom_ack),
      .rom_q      (rom_q),
      .ram_addr   (ram_addr),
      .ram_req    (ram_req),
      .ram_we     (ram_we),
      .ram_d      (ram_d),
      .ram_ack    (ram_ack),
      .ram_q      (ram_q),
      .cart_do    (cart_do),
      .late_cnt   (late_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Compare cart_do against the oldest expected read byte.
   task automatic check_sb(input string tag);
      logic [7:0] exp;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s: got %0h expected <queued byte>", tag, cart_do);
      end else begin
         exp = sb.pop_front();
         check(tag, {24'h0, cart_do}, {24'h0, exp});
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_f();
      sysclkf_ce = 1'b1;
      tick();
      sysclkf_ce = 1'b0;
   endtask

   task automatic pulse_r();
      sysclkr_ce = 1'b1;
      tick();
      sysclkr_ce = 1'b0;
   endtask

   task automatic rom_ack_pulse(input logic [15:0] q);
      rom_q   = q;
      rom_ack = 1'b1;
      tick();
      rom_ack = 1'b0;
   endtask

   task automatic ram_ack_pulse(input logic [7:0] q);
      ram_q   = q;
      ram_ack = 1'b1;
      tick();
      ram_ack = 1'b0;
   endtask

   task automatic start_read(input logic [1:0] mode, input logic [23:0] addr);
      map_mode = mode;
      ca       = addr;
      romsel_n = 1'b0;
      cpurd_n  = 1'b0;
      pulse_f();
      romsel_n = 1'b1;
      cpurd_n  = 1'b1;
   endtask

   task automatic bus_idle();
      romsel_n = 1'b1;
      cpurd_n  = 1'b1;
      cpuwr_n  = 1'b1;
   endtask

   initial begin
      tick();
      tick();
      check("rst_rom_req", {31'h0, rom_req}, 32'h0);
      check("rst_ram_req", {31'h0, ram_req}, 32'h0);
      check("rst_ram_we", {31'h0, ram_we}, 32'h0);
      check("rst_rom_addr", {8'h0, rom_addr}, 32'h0);
      check("rst_ram_addr", {15'h0, ram_addr}, 32'h0);
      check("rst_ram_d", {24'h0, ram_d}, 32'h0);
      check("rst_cart_do", {24'h0, cart_do}, 32'hFF);
      check("rst_late", {24'h0, late_cnt}, 32'h0);
      rst_n = 1'b1;
      tick();

      // LoROM read, high byte.
      start_read(2'd0, 24'h818123);
      sb.push_back(8'hBE);
      check("lo_rom_addr", {8'h0, rom_addr}, 32'h008123);
      check("lo_rom_req", {31'h0, rom_req}, 32'h1);
      tick();
      tick();
      check("lo_rom_req_hold", {31'h0, rom_req}, 32'h1);
      check("lo_wait_openbus", {24'h0, cart_do}, 32'hFF);
      rom_ack_pulse(16'hBEEF);
      check("lo_rom_req_fall", {31'h0, rom_req}, 32'h0);
      check_sb("lo_rom_data");

      // HiROM even and odd addresses.
      start_read(2'd1, 24'hC12344);
      sb.push_back(8'h34);
      check("hi_rom_addr", {8'h0, rom_addr}, 32'h012344);
      rom_ack_pulse(16'h1234);
      check_sb("hi_rom_data_lo");
      start_read(2'd1, 24'hC12345);
      sb.push_back(8'h12);
      rom_ack_pulse(16'h1234);
      check_sb("hi_rom_data_hi");

      // ExHiROM: bank bit 22 is the inverse of ca[23].
      start_read(2'd2, 24'h412344);
      sb.push_back(8'h5A);
      check("exhi_rom_addr", {8'h0, rom_addr}, 32'h412344);
      rom_ack_pulse(16'hA55A);
      check_sb("exhi_rom_data");

      // Masked LoROM address, ack in the cycle the request rose.
      rom_mask = 24'h07FFFF;
      start_read(2'd0, 24'hFF8000);
      sb.push_back(8'h99);
      check("mask_rom_addr", {8'h0, rom_addr}, 32'h078000);
      rom_ack_pulse(16'h0099);
      check_sb("mask_rom_data");
      rom_mask = 24'hFFFFFF;

      // LoROM save-RAM write.
      map_mode = 2'd0;
      ca       = 24'h700010;
      romsel_n = 1'b0;
      cpuwr_n  = 1'b0;
      pulse_f();
      check("wr_arm_no_req", {31'h0, ram_req}, 32'h0);
      check("wr_ram_addr", {15'h0, ram_addr}, 32'h10);
      di = 8'h5A;
      pulse_r();
      bus_idle();
      check("wr_ram_req", {31'h0, ram_req}, 32'h1);
      check("wr_ram_we", {31'h0, ram_we}, 32'h1);
      check("wr_ram_d", {24'h0, ram_d}, 32'h5A);
      ram_ack_pulse(8'h00);
      check("wr_ram_req_fall", {31'h0, ram_req}, 32'h0);
      check("wr_cart_openbus", {24'h0, cart_do}, 32'h5A);

      // LoROM save-RAM read.
      ca       = 24'h700010;
      romsel_n = 1'b0;
      cpurd_n  = 1'b0;
      pulse_f();
      bus_idle();
      sb.push_back(8'h77);
      check("rd_ram_req", {31'h0, ram_req}, 32'h1);
      check("rd_ram_we", {31'h0, ram_we}, 32'h0);
      check("rd_rom_req_quiet", {31'h0, rom_req}, 32'h0);
      ram_ack_pulse(8'h77);
      check("rd_ram_req_fall", {31'h0, ram_req}, 32'h0);
      check_sb("rd_ram_data");

      // No save RAM: the write decodes as an ignored ROM write.
      ram_mask = '0;
      ca       = 24'h700010;
      romsel_n = 1'b0;
      cpuwr_n  = 1'b0;
      pulse_f();
      bus_idle();
      check("nomask_ram_req", {31'h0, ram_req}, 32'h0);
      check("nomask_rom_req", {31'h0, rom_req}, 32'h0);
      di = 8'h3C;
      pulse_r();
      check("nomask_ram_req2", {31'h0, ram_req}, 32'h0);
      check("nomask_openbus", {24'h0, cart_do}, 32'h3C);
      ram_mask = 17'h1FFFF;

      // Late ack and an access dropped while busy.
      start_read(2'd0, 24'h818123);
      di = 8'h11;
      pulse_r();
      check("late_r", {24'h0, late_cnt}, 32'h1);
      start_read(2'd0, 24'h818124);
      check("late_busy", {24'h0, late_cnt}, 32'h2);
      check("late_busy_addr", {8'h0, rom_addr}, 32'h008123);
      check("late_busy_req", {31'h0, rom_req}, 32'h1);
      // Both late conditions in one cycle count once.
      ca         = 24'h818123;
      romsel_n   = 1'b0;
      cpurd_n    = 1'b0;
      sysclkf_ce = 1'b1;
      sysclkr_ce = 1'b1;
      tick();
      sysclkf_ce = 1'b0;
      sysclkr_ce = 1'b0;
      bus_idle();
      check("late_both", {24'h0, late_cnt}, 32'h3);
      sb.push_back(8'hBE);
      rom_ack_pulse(16'hBEEF);
      check_sb("late_data");

      // Saturation.
      start_read(2'd0, 24'h818123);
      for (int i = 0; i < 300; i++) begin
         pulse_r();
      end
      check("late_sat", {24'h0, late_cnt}, 32'hFF);
      rom_ack_pulse(16'h0000);
      check("late_sat_ack", {31'h0, rom_req}, 32'h0);

      // Reset in the middle of a ROM access.
      start_read(2'd0, 24'h818123);
      check("rst_mid_req_pre", {31'h0, rom_req}, 32'h1);
      rst_n = 1'b0;
      #1;
      check("rst_mid_req", {31'h0, rom_req}, 32'h0);
      check("rst_mid_cart", {24'h0, cart_do}, 32'hFF);
      tick();
      rst_n = 1'b1;
      tick();
      rom_ack_pulse(16'h4242);
      check("rst_late_ack_req", {31'h0, rom_req}, 32'h0);
      check("rst_late_ack_cart", {24'h0, cart_do}, 32'hFF);
      check("rst_late_ack_cnt", {24'h0, late_cnt}, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
